// File: rtl/context_store_pkg.sv
// Shared FSM state type and width helpers for the context save/restore engine.
package context_store_pkg;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FINISH} state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_NUM_CTX  = 4;
  localparam int DEFAULT_IDX_W    = idx_width(DEFAULT_NUM_REGS);
  localparam int DEFAULT_CTX_W    = idx_width(DEFAULT_NUM_CTX);

endpackage

// File: rtl/context_store_ram.sv
// Context slot storage: one synchronous write port, two combinational read ports
// (register word and stored PC word).
module ctx_ram #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 132,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [XLEN-1:0]   rdata,
  input  logic [ADDR_W-1:0] pc_raddr,
  output logic [XLEN-1:0]   pc_rdata
);

  logic [XLEN-1:0] mem [0:DEPTH-1];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata    = mem[raddr];
  assign pc_rdata = mem[pc_raddr];

endmodule

// File: rtl/context_store.sv
// Saves the register file plus PC into one of NUM_CTX slots, or restores a slot
// back into the register file, one register per cycle.
module context_store
  import context_store_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_CTX  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          SAVE_REQ,
  input  logic                          RESTORE_REQ,
  input  logic [idx_width(NUM_CTX)-1:0] CTX_ID,
  input  logic [XLEN-1:0]               PC_IN,
  input  logic [XLEN-1:0]               RF_RDATA,
  output logic [idx_width(NUM_REGS)-1:0] RF_IDX,
  output logic                          RF_WE,
  output logic [XLEN-1:0]               RF_WDATA,
  output logic [XLEN-1:0]               PC_OUT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  output logic [NUM_CTX-1:0]            CTX_VALID
);

  localparam int IDX_W      = idx_width(NUM_REGS);
  localparam int CTX_W      = idx_width(NUM_CTX);
  localparam int SLOT_WORDS = NUM_REGS + 1;
  localparam int DEPTH      = NUM_CTX * SLOT_WORDS;
  localparam int ADDR_W     = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CTX_W-1:0]   ctx_reg, ctx_next;
  logic [XLEN-1:0]    pc_reg, pc_next;
  logic [XLEN-1:0]    pc_out_reg, pc_out_next;
  logic [NUM_CTX-1:0] valid_reg, valid_next;
  logic               err_reg, err_next;
  logic               save_op_reg, save_op_next;

  logic               id_in_range, id_valid;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr, reg_addr, pc_addr;
  logic [XLEN-1:0]    ram_wdata, reg_rdata, pc_rdata;

  // Each slot holds NUM_REGS register words followed by the PC word.
  assign reg_addr = ADDR_W'(32'(ctx_reg) * SLOT_WORDS + 32'(idx_reg));
  assign pc_addr  = ADDR_W'(32'(ctx_reg) * SLOT_WORDS + NUM_REGS);

  // The PC word is written during FINISH, after the last register word.
  assign ram_we    = (state_reg == SAVE) || ((state_reg == FINISH) && save_op_reg);
  assign ram_waddr = (state_reg == SAVE) ? reg_addr : pc_addr;
  assign ram_wdata = (state_reg == SAVE) ? RF_RDATA : pc_reg;

  ctx_ram #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK      (CLK),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .raddr    (reg_addr),
    .rdata    (reg_rdata),
    .pc_raddr (pc_addr),
    .pc_rdata (pc_rdata)
  );

  always_comb begin
    id_in_range = 32'(CTX_ID) < NUM_CTX;
    id_valid    = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if ((32'(CTX_ID) == c) && valid_reg[c]) id_valid = 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ctx_next     = ctx_reg;
    pc_next      = pc_reg;
    pc_out_next  = pc_out_reg;
    valid_next   = valid_reg;
    err_next     = 1'b0;
    save_op_next = save_op_reg;
    case (state_reg)
      IDLE: begin
        if (SAVE_REQ) begin
          if (id_in_range) begin
            state_next   = SAVE;
            idx_next     = '0;
            ctx_next     = CTX_ID;
            pc_next      = PC_IN;
            save_op_next = 1'b1;
            for (int c = 0; c < NUM_CTX; c++) begin
              if (32'(CTX_ID) == c) valid_next[c] = 1'b0;
            end
          end else begin
            err_next = 1'b1;
          end
        end else if (RESTORE_REQ) begin
          if (id_valid) begin
            state_next   = RESTORE;
            idx_next     = '0;
            ctx_next     = CTX_ID;
            save_op_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SAVE, RESTORE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = FINISH;
          if (state_reg == RESTORE) pc_out_next = pc_rdata;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      FINISH: begin
        state_next = IDLE;
        if (save_op_reg) begin
          for (int c = 0; c < NUM_CTX; c++) begin
            if (32'(ctx_reg) == c) valid_next[c] = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      ctx_reg     <= '0;
      pc_reg      <= '0;
      pc_out_reg  <= '0;
      valid_reg   <= '0;
      err_reg     <= 1'b0;
      save_op_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      ctx_reg     <= ctx_next;
      pc_reg      <= pc_next;
      pc_out_reg  <= pc_out_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      save_op_reg <= save_op_next;
    end
  end

  assign BUSY      = (state_reg == SAVE) || (state_reg == RESTORE);
  assign DONE      = (state_reg == FINISH);
  assign ERR       = err_reg;
  assign RF_IDX    = BUSY ? idx_reg : '0;
  // x0 is hard-wired zero in the register file, so it is never written back.
  assign RF_WE     = (state_reg == RESTORE) && (idx_reg != '0);
  assign RF_WDATA  = (state_reg == RESTORE) ? reg_rdata : '0;
  assign PC_OUT    = pc_out_reg;
  assign CTX_VALID = valid_reg;

endmodule

// File: doc/context_store.md
CONTEXT_STORE -- requirements
Module: context_store

Interface
REQ-001 Parameter XLEN, default 32, register and PC width in bits.
REQ-002 Parameter NUM_REGS, default 32, registers per context; at least 2.
REQ-003 Parameter NUM_CTX, default 4, stored context slots; at least 1.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 SAVE_REQ  input  1  request to copy register file and PC_IN into slot CTX_ID.
REQ-007 RESTORE_REQ  input  1  request to copy slot CTX_ID back into register file and PC_OUT.
REQ-008 CTX_ID  input  clog2(NUM_CTX), min 1  target slot, sampled on request acceptance.
REQ-009 PC_IN  input  XLEN  PC to save, sampled on SAVE acceptance.
REQ-010 RF_RDATA  input  XLEN  register-file read data for RF_IDX, combinational.
REQ-011 RF_IDX  output  clog2(NUM_REGS)  register-file index being read or written.
REQ-012 RF_WE  output  1  register-file write enable during restore.
REQ-013 RF_WDATA  output  XLEN  register-file write data.
REQ-014 PC_OUT  output  XLEN  restored PC, held until next restore.
REQ-015 BUSY  output  1  transfer in progress; requests ignored while high.
REQ-016 DONE  output  1  one-cycle pulse on transfer completion.
REQ-017 ERR  output  1  one-cycle pulse: restore of an invalid slot or CTX_ID >= NUM_CTX.
REQ-018 CTX_VALID  output  NUM_CTX  per-slot bit, set by a completed save.

Function
REQ-019 FSM states: IDLE, SAVE, RESTORE, FINISH.
REQ-020 In IDLE, a request is accepted on a clock edge; next state is SAVE or RESTORE, index counter is 0, and BUSY rises the following cycle.
REQ-021 When SAVE_REQ and RESTORE_REQ are both high, SAVE wins and RESTORE is dropped.
REQ-022 SAVE: for i = 0..NUM_REGS-1, one per cycle, RF_IDX=i and RF_RDATA is written into slot[CTX_ID][i] at the cycle's edge; RF_WE stays 0.
REQ-023 RESTORE: for i = 0..NUM_REGS-1, one per cycle, RF_IDX=i, RF_WDATA=slot[CTX_ID][i], and RF_WE=1 except at i=0, where RF_WE=0 (x0 is never written).
REQ-024 After index NUM_REGS-1 the FSM enters FINISH for one cycle: DONE=1, BUSY=0, then it returns to IDLE.
REQ-025 Latency from accept edge to DONE is NUM_REGS+1 cycles; a new request is accepted no earlier than the FINISH-cycle edge.
REQ-026 On save completion (FINISH), CTX_VALID[CTX_ID] is set and the stored PC is committed; an aborted save leaves that bit cleared.
REQ-027 CTX_VALID[CTX_ID] clears when a save to that slot is accepted.
REQ-028 On restore completion, PC_OUT is loaded from the stored PC in the same cycle that DONE is high.
REQ-029 A restore of an invalid or out-of-range slot is not started: ERR pulses for one cycle after the accept edge, the FSM stays IDLE, and there are no RF writes.
REQ-030 Saving to an out-of-range CTX_ID raises ERR, the FSM stays IDLE, and storage is unchanged.
REQ-031 The index counter has clog2(NUM_REGS) bits, is not allowed to wrap, and the terminal count is NUM_REGS-1.
REQ-032 While not in RESTORE, RF_WDATA=0 and RF_WE=0.

Reset
REQ-033 While RESET is 0, the block immediately enters IDLE with BUSY, DONE, ERR, RF_WE, RF_IDX, RF_WDATA, PC_OUT and CTX_VALID all 0.
REQ-034 Slot storage is not reset; it is unreadable until a save completes, which REQ-029 enforces.
REQ-035 Reset mid-transfer aborts the transfer without DONE, and partial restore writes already made are not undone.

Structure
REQ-036 A shared package holds the FSM state enum and the derived width constants (index and context-ID widths).
REQ-037 Storage is a sub-module ctx_ram: a synchronous single-write-port array of NUM_CTX*(NUM_REGS+1) XLEN-bit words with combinational read.

Verification
REQ-038 Reset: hold RESET=0 mid-SAVE at i=10 -> all outputs 0, CTX_VALID=0, no DONE.
REQ-039 Save then restore: RF holds x_i=0x100+i, PC_IN=0x8000, save ctx 2 -> DONE at cycle 33, CTX_VALID=4'b0100. Restore ctx 2 -> 31 writes with RF_WDATA=0x100+i for i=1..31, then PC_OUT=0x8000.
REQ-040 Restore of never-saved ctx 1 -> ERR single pulse, BUSY stays 0, no RF_WE.
REQ-041 SAVE_REQ and RESTORE_REQ high together with ctx 0 -> save executes, no RF_WE, DONE at cycle 33.
REQ-042 SAVE_REQ pulsed while BUSY -> ignored, and the original transfer completes unchanged.
REQ-043 Parameter sweep NUM_REGS=16, NUM_CTX=1, XLEN=64 -> latency 17, correct round-trip data.
